// File: rtl/stepper_seq_ctrl_if.sv
// Command channel of the stepper motion sequencer: a valid/ready handshake carrying
// direction, step count and step period.
interface stepper_seq_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_seq_ctrl.sv
// Motion sequencer for the 3-phase stepper: turns move commands into Sin + StepEn pulses
// and tracks absolute position. Define STEPPER_ACCEL_EN for the trapezoidal speed ramp.
module stepper_seq_ctrl #(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 16,
    parameter int POS_W     = 16,
    parameter int DIR_SETUP = 4
`ifdef STEPPER_ACCEL_EN
    ,
    parameter int START_PER = 1000,
    parameter int RAMP_DEC  = 8
`endif
) (
    input  logic              CP,
    input  logic              nCR,
    stepper_seq_ctrl_if.slave cmd,
    input  logic              abort,
    output logic              Sin,
    output logic              StepEn,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [POS_W-1:0]  pos
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] MIN_PER  = PER_W'(2);

    state_t           state_q, state_d;
    logic             sin_q, sin_d;
    logic             step_en_q, step_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [SET_W-1:0] setup_cnt_q, setup_cnt_d;

    logic [PER_W-1:0] p_clamp;
    logic [PER_W-1:0] ivl_per;
    logic             fire;

    // Periods below 2 would put StepEn high on back-to-back cycles.
    assign p_clamp = (cmd.cmd_period < MIN_PER) ? MIN_PER : cmd.cmd_period;

`ifdef STEPPER_ACCEL_EN
    localparam logic [PER_W-1:0] START_V = PER_W'(START_PER);
    localparam logic [PER_W-1:0] DEC_V   = PER_W'(RAMP_DEC);

    logic [PER_W-1:0] cur_per_q, cur_per_d;
    logic [CNT_W-1:0] accel_cnt_q, accel_cnt_d;
    logic [PER_W-1:0] top_per, first_per;
    logic [PER_W:0]   dec_floor, inc_sum;

    assign top_per   = (per_q > START_V) ? per_q : START_V;
    assign first_per = (p_clamp > START_V) ? p_clamp : START_V;
    // One extra bit so the ramp arithmetic never wraps.
    assign dec_floor = {1'b0, per_q} + {1'b0, DEC_V};
    assign inc_sum   = {1'b0, cur_per_q} + {1'b0, DEC_V};
    assign ivl_per   = cur_per_q;
`else
    assign ivl_per   = per_q;
`endif

    assign fire = (timer_q == (ivl_per - PER_W'(1)));

    always_comb begin
        state_d     = state_q;
        sin_d       = sin_q;
        step_en_d   = 1'b0;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        pos_d       = pos_q;
        remaining_d = remaining_q;
        per_d       = per_q;
        timer_d     = timer_q;
        setup_cnt_d = setup_cnt_q;
`ifdef STEPPER_ACCEL_EN
        cur_per_d   = cur_per_q;
        accel_cnt_d = accel_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    sin_d       = cmd.cmd_dir;
                    aborted_d   = 1'b0;
                    remaining_d = cmd.cmd_steps;
                    per_d       = p_clamp;
                    setup_cnt_d = '0;
`ifdef STEPPER_ACCEL_EN
                    cur_per_d   = first_per;
                    accel_cnt_d = '0;
`endif
                    if (cmd.cmd_steps == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (setup_cnt_q == SET_LAST) begin
                    state_d = S_RUN;
                    timer_d = PER_W'(1);
                end else begin
                    setup_cnt_d = setup_cnt_q + SET_W'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (fire) begin
                    step_en_d   = 1'b1;
                    timer_d     = '0;
                    remaining_d = remaining_q - CNT_W'(1);
                    pos_d       = sin_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
`ifdef STEPPER_ACCEL_EN
                    // Speed up while more steps remain than were spent accelerating.
                    if (remaining_d > accel_cnt_q) begin
                        if (cur_per_q > per_q) begin
                            cur_per_d   = ({1'b0, cur_per_q} >= dec_floor) ? (cur_per_q - DEC_V) : per_q;
                            accel_cnt_d = accel_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cur_per_d = (inc_sum > {1'b0, top_per}) ? top_per : inc_sum[PER_W-1:0];
                    end
`endif
                end else begin
                    timer_d = timer_q + PER_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q     <= S_IDLE;
            sin_q       <= 1'b0;
            step_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            pos_q       <= '0;
            remaining_q <= '0;
            per_q       <= MIN_PER;
            timer_q     <= '0;
            setup_cnt_q <= '0;
`ifdef STEPPER_ACCEL_EN
            cur_per_q   <= MIN_PER;
            accel_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sin_q       <= sin_d;
            step_en_q   <= step_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_d;
            per_q       <= per_d;
            timer_q     <= timer_d;
            setup_cnt_q <= setup_cnt_d;
`ifdef STEPPER_ACCEL_EN
            cur_per_q   <= cur_per_d;
            accel_cnt_q <= accel_cnt_d;
`endif
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign Sin           = sin_q;
    assign StepEn        = step_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign pos           = pos_q;
endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Scoreboard bench for stepper_seq_ctrl: a driver predicts every StepEn and done event
// from the move rules, a negedge monitor pops and compares them as the DUT produces them.
module tb_stepper_seq_ctrl;
    localparam int DS = 4;
`ifdef STEPPER_ACCEL_EN
    localparam int SP = 20;
    localparam int RD = 8;
`endif

    typedef struct {
        int          obs;
        logic [15:0] pos;
        bit          dir;
    } step_t;

    typedef struct {
        int          obs;
        bit          ab;
        logic [15:0] pos;
    } done_t;

    logic        CP;
    logic        nCR;
    logic        abort;
    logic        Sin, StepEn, busy, done, aborted;
    logic [15:0] pos;

    stepper_seq_ctrl_if #(.CNT_W(16), .PER_W(16)) cmd_if ();

    stepper_seq_ctrl #(
        .CNT_W(16), .PER_W(16), .POS_W(16), .DIR_SETUP(DS)
`ifdef STEPPER_ACCEL_EN
        , .START_PER(SP), .RAMP_DEC(RD)
`endif
    ) dut (
        .CP(CP), .nCR(nCR), .cmd(cmd_if), .abort(abort),
        .Sin(Sin), .StepEn(StepEn), .busy(busy), .done(done),
        .aborted(aborted), .pos(pos)
    );

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    bit          sb_en = 0;
    logic [15:0] model_pos = 16'h0;
    bit          last_ab = 0;
    step_t       exp_step[$];
    done_t       exp_done[$];

    initial CP = 1'b0;
    always #5 CP = ~CP;
    always @(posedge CP) edge_n <= edge_n + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: compares each observed StepEn/done with the next predicted event.
    step_t s_m;
    done_t d_m;
    bit    prev_step = 0;
    bit    ready_chk = 0;
    always @(negedge CP) begin
        if (sb_en && nCR) begin
            if (ready_chk) begin
                check("ready_after_done", cmd_if.cmd_ready, 1);
                check("busy_after_done", busy, 0);
                ready_chk = 0;
            end
            if (StepEn) begin
                check("step_not_back_to_back", prev_step, 0);
                if (exp_step.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step actual=StepEn expected=none (edge %0d)", edge_n);
                end else begin
                    s_m = exp_step.pop_front();
                    check("step_time", edge_n, s_m.obs);
                    check("step_pos", pos, s_m.pos);
                    check("step_dir", Sin, s_m.dir);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=none (edge %0d)", edge_n);
                end else begin
                    d_m = exp_done.pop_front();
                    check("done_time", edge_n, d_m.obs);
                    check("done_aborted", aborted, d_m.ab);
                    check("done_pos", pos, d_m.pos);
                    check("steps_missing", exp_step.size(), 0);
                    check("busy_in_done", busy, 1);
                end
                ready_chk = 1;
            end
            prev_step = StepEn;
        end else begin
            prev_step = 0;
        end
    end

    // Issue one move; abort_at: -1 none, 0 during first SETUP cycle, k during k-th StepEn.
    task automatic issue(input bit dir, input int steps, input int period,
                         input int abort_at, input bit abort_with_cmd);
        int p, cur, obs, a_edge, x, n_keep, done_obs, guard;
        bit ab;
        int obs_l[$];
`ifdef STEPPER_ACCEL_EN
        int top, ac, rem, nw;
`endif
        guard = 0;
        x = -1;
        @(negedge CP);
        while (!cmd_if.cmd_ready && guard < 200) begin
            @(negedge CP);
            guard++;
        end
        check("ready_before_issue", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_steps  = 16'(steps);
        cmd_if.cmd_period = 16'(period);
        abort             = abort_with_cmd;
        a_edge = edge_n + 1;

        p = (period < 2) ? 2 : period;
`ifdef STEPPER_ACCEL_EN
        top = (SP > p) ? SP : p;
        cur = top;
        ac  = 0;
`else
        cur = p;
`endif
        obs = a_edge + DS - 1;
        for (int k = 1; k <= steps; k++) begin
            obs += cur;
            obs_l.push_back(obs);
`ifdef STEPPER_ACCEL_EN
            rem = steps - k;
            if (rem > ac) begin
                nw = (cur - RD > p) ? cur - RD : p;
                if (nw < cur) ac++;
                cur = nw;
            end else begin
                cur = (cur + RD < top) ? cur + RD : top;
            end
`endif
        end

        ab = 0;
        n_keep = steps;
        if (steps > 0 && abort_at >= 0 && abort_at <= steps) begin
            ab = 1;
            n_keep = abort_at;
            x = (abort_at == 0) ? a_edge : obs_l[abort_at - 1];
        end
        for (int k = 0; k < n_keep; k++) begin
            model_pos = dir ? model_pos + 16'd1 : model_pos - 16'd1;
            exp_step.push_back('{obs_l[k], model_pos, dir});
        end
        if (steps == 0)  done_obs = a_edge;
        else if (ab)     done_obs = x + 1;
        else             done_obs = obs_l[steps - 1] + 1;
        exp_done.push_back('{done_obs, ab, model_pos});
        last_ab = ab;
        $display("move dir=%0d steps=%0d period=%0d abort_at=%0d accept_edge=%0d done_edge=%0d pos=%0h",
                 dir, steps, period, abort_at, a_edge, done_obs, model_pos);

        @(posedge CP);
        guard = 0;
        while (exp_done.size() != 0 && guard < 3000) begin
            @(negedge CP);
            cmd_if.cmd_valid = 1'b0;
            abort = ab && (edge_n == x);
            if (edge_n == a_edge) check("sin_after_accept", Sin, dir);
            // Commands offered while busy must be ignored.
            if (!cmd_if.cmd_ready && $urandom_range(0, 3) == 0) begin
                cmd_if.cmd_valid  = 1'b1;
                cmd_if.cmd_dir    = 1'($urandom);
                cmd_if.cmd_steps  = 16'($urandom_range(0, 9));
                cmd_if.cmd_period = 16'($urandom_range(0, 9));
            end
            guard++;
        end
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        if (exp_done.size() != 0) begin
            check("done_timeout", exp_done.size(), 0);
            exp_done.delete();
            exp_step.delete();
        end
    endtask

    initial begin
        int guard;
        nCR = 1'b0;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir = 1'b0;
        cmd_if.cmd_steps = '0;
        cmd_if.cmd_period = '0;
        repeat (2) @(negedge CP);
        check("rst_sin", Sin, 0);
        check("rst_stepen", StepEn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_pos", pos, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        nCR = 1'b1;

        // Reset in the middle of a move.
        @(negedge CP);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir = 1'b1;
        cmd_if.cmd_steps = 16'd5;
        cmd_if.cmd_period = 16'd3;
        @(negedge CP);
        cmd_if.cmd_valid = 1'b0;
        guard = 0;
        while (!StepEn && guard < 40) begin
            @(negedge CP);
            guard++;
        end
        check("pre_reset_step_seen", StepEn, 1);
        check("pre_reset_pos", pos, 1);
        nCR = 1'b0;
        #1;
        check("midrun_rst_stepen", StepEn, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_pos", pos, 0);
        check("midrun_rst_ready", cmd_if.cmd_ready, 1);
        repeat (3) begin
            @(negedge CP);
            check("rst_hold_no_step", StepEn, 0);
        end
        nCR = 1'b1;
        model_pos = 16'h0;
        sb_en = 1;

        issue(1'b1, 3, 5, -1, 1'b0);
        check("fwd_pos", pos, 3);
        issue(1'b0, 2, 0, -1, 1'b0);
        check("rev_clamp_pos", pos, 1);
        issue(1'b1, 0, 7, -1, 1'b0);
        check("zero_steps_pos", pos, 1);
        issue(1'b0, 1, 3, -1, 1'b0);
        issue(1'b0, 1, 3, -1, 1'b0);
        check("wrap_pos", pos, 16'hFFFF);
        issue(1'b1, 10, 4, 3, 1'b0);
        check("abort_pos", pos, 2);
        check("abort_held", aborted, 1);

        // abort while idle is ignored
        repeat (3) begin
            @(negedge CP);
            abort = 1'b1;
        end
        @(negedge CP);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_ready", cmd_if.cmd_ready, 1);
        check("idle_abort_pos", pos, 2);

        issue(1'b0, 2, 3, -1, 1'b1);
        check("valid_with_abort_aborted", aborted, 0);
        issue(1'b1, 3, 2, 0, 1'b0);
`ifdef STEPPER_ACCEL_EN
        issue(1'b1, 6, 4, -1, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            int st;
            st = $urandom_range(0, 6);
            issue(1'($urandom), st, $urandom_range(0, 6),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, st) : -1,
                  1'($urandom_range(0, 7) == 0));
        end
        repeat (3) @(negedge CP);
        check("final_pos", pos, model_pos);
        check("final_aborted", aborted, last_ab);
        check("leftover_steps", exp_step.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
